uart_tx_frame_piso: RTL and testbench
=====================================

Name: uart_tx_frame_piso

Overview:
UART transmit framer and parallel-in/serial-out stage, sitting directly downstream of the Tx parity unit.
- Accepts a data byte with a one-cycle Send strobe and holds it in DataReg for the whole frame. DataReg drives the parity unit's RegIn.
- Consumes the parity unit's ParityOut as ParityIn.
- Serialises start, data (LSB first), optional parity and stop bits onto TxOut, one bit per BaudTick from the baud generator.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; fixed at 8 while paired with the 8-bit parity unit.

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
BaudTick  input  1  one-Clock-cycle enable, one pulse per bit period
Send  input  1  request strobe; accepted only when Busy=0
DataIn  input  DATA_WIDTH  byte to transmit, sampled on acceptance
ParityType  input  2  00 none, 01 odd, 10 even, 11 none; sampled on acceptance
StopBits  input  1  0 = one stop bit, 1 = two stop bits; sampled on acceptance
ParityIn  input  1  parity bit from parity unit (computed from DataReg)
DataReg  output  DATA_WIDTH  latched frame data, feeds parity unit RegIn
TxOut  output  1  serial line, idle high, registered
Busy  output  1  high from the cycle after acceptance until the frame completes
Done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, any time including mid-frame):
  - TxOut=1, Busy=0, Done=0, DataReg=0.
  - State IDLE, bit counter 0.
  - Partial frame is abandoned; no Done pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - Send=1 while Busy=0 in IDLE latches DataIn, ParityType and StopBits.
  - Next cycle: Busy=1, state START.
  - Send while Busy=1 is ignored, with no queuing.
- Bit timing:
  - TxOut changes only on cycles with BaudTick=1, except at reset.
  - The first BaudTick strictly after the acceptance cycle drives TxOut=0 (start bit).
  - A BaudTick coinciding with the acceptance cycle does not launch.
- Launch order and transitions, one bit per BaudTick:
  - START -> DATA: D0..D7 LSB first; counter 0..7, wraps to 0 on leaving DATA.
  - DATA -> PARITY if ParityType is 01 or 10; otherwise DATA -> STOP.
  - PARITY: TxOut = ParityIn, sampled on the launching BaudTick. DataReg is stable, so the parity unit output is settled.
  - STOP: TxOut=1 for 1 or 2 BaudTicks per the latched StopBits.
- Frame length N = 1 + 8 + P + S, with P in {0,1} and S in {1,2}; N ranges 10..12.
- Completion:
  - On the BaudTick that ends the last stop bit (tick N+1 counted from start launch), Done=1 for that one cycle and state returns to IDLE.
  - Busy=0 from the following cycle.
  - A new Send is accepted in the cycle after Done. Back-to-back frames have no extra idle bit beyond the stop bits.
- Missing BaudTicks hold the current bit indefinitely; there is no timeout.
- DataReg holds its value after Done until the next acceptance.
- ParityType/StopBits/DataIn changes during Busy have no effect on the frame in progress.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE2=11;
  - stop encodings STOP_ONE=0, STOP_TWO=1;
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - DATA_WIDTH default.
- No sub-module. The parity unit is instantiated beside this block at the Tx top level, wired DataReg -> RegIn and ParityOut -> ParityIn.

Test Plan:
- DataIn=0x55, ParityType=00, StopBits=0, BaudTick every 16 cycles -> TxOut sequence 0,1,0,1,0,1,0,1,0,1 (10 bits); Done pulses once at tick 11; Busy high exactly across the frame.
- DataIn=0x07, ParityType=01 -> parity bit 0; ParityType=10 -> parity bit 1; frame length 11 bits, stop=1.
- DataIn=0x55, ParityType=10, StopBits=1 -> parity bit 0, two stop bits, 12-bit frame, Done at tick 13.
- Second Send during Busy with DataIn=0xFF -> ignored, first frame unchanged. Send the cycle after Done with 0xA3 -> accepted; its start bit launches on the next BaudTick.
- Reset asserted mid-DATA (after bit D3) -> TxOut=1, Busy=0 immediately without waiting for Clock; no Done. After release, new Send of 0x3C produces a clean full frame.
- Send coincident with BaudTick in IDLE -> TxOut stays 1 that tick; start bit appears on the next BaudTick.

Source files
------------

// File: rtl/uart_tx_frame_piso_pkg.sv
// Shared encodings and state type for the UART transmit framer.
// The parity unit beside this block uses the same parity encodings.
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic has_parity(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_frame_piso_if.sv
// Frame request / serial output bundle of the UART transmit framer.
// Signal prefixes are from the framer's point of view (slave side).
interface uart_tx_frame_piso_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
);
    logic                  i_baud_tick;
    logic                  i_send;
    logic [DATA_WIDTH-1:0] i_data_in;
    logic [1:0]            i_parity_type;
    logic                  i_stop_bits;
    logic                  i_parity_in;
    logic [DATA_WIDTH-1:0] o_data_reg;
    logic                  o_tx_out;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        output i_baud_tick, i_send, i_data_in, i_parity_type, i_stop_bits, i_parity_in,
        input  o_data_reg, o_tx_out, o_busy, o_done
    );

    modport slave (
        input  i_baud_tick, i_send, i_data_in, i_parity_type, i_stop_bits, i_parity_in,
        output o_data_reg, o_tx_out, o_busy, o_done
    );
endinterface

// File: rtl/uart_tx_frame_piso.sv
// UART transmit framer: latches a byte and shifts start, data (LSB first),
// optional parity and 1-2 stop bits onto the line, one bit per baud tick.
//
// state  | meaning
// IDLE   | line high; accepts Send when not busy (busy=1 here only in the Done cycle)
// START  | frame accepted, next baud tick launches the start bit
// DATA   | next baud tick launches data bit r_bit_cnt
// PARITY | next baud tick launches the parity bit from the parity unit
// STOP   | r_bit_cnt counts stop bits launched; the tick after the last one ends the frame
module uart_tx_frame_piso
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    uart_tx_frame_piso_if.slave    bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_data_reg;
    logic [1:0]            r_parity_type;
    logic                  r_stop_bits;
    logic                  r_tx_out;
    logic                  r_busy;
    logic                  r_done;

    logic w_more_stop;

    // Stop bit 1 is always sent; stop bit 2 only when two were requested.
    assign w_more_stop = (r_bit_cnt == '0) ||
                         ((r_bit_cnt == CNT_W'(1)) && (r_stop_bits == STOP_TWO));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_data_reg    <= '0;
            r_parity_type <= PAR_NONE;
            r_stop_bits   <= STOP_ONE;
            r_tx_out      <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (bus.i_send) begin
                        r_data_reg    <= bus.i_data_in;
                        r_parity_type <= bus.i_parity_type;
                        r_stop_bits   <= bus.i_stop_bits;
                        r_busy        <= 1'b1;
                        r_state       <= START;
                    end
                end
                START: begin
                    if (bus.i_baud_tick) begin
                        r_tx_out  <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (bus.i_baud_tick) begin
                        r_tx_out <= r_data_reg[r_bit_cnt];
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= has_parity(r_parity_type) ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.i_baud_tick) begin
                        r_tx_out <= bus.i_parity_in;
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    if (bus.i_baud_tick) begin
                        if (w_more_stop) begin
                            r_tx_out  <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else begin
                            r_done    <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    r_tx_out  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_data_reg = r_data_reg;
    assign bus.o_tx_out   = r_tx_out;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;

endmodule

// File: tb/tb_uart_tx_frame_piso.sv
// Scoreboard bench for uart_tx_frame_piso: each accepted frame pushes its
// expected per-tick line values; the monitor pops one entry per baud tick.
module tb_uart_tx_frame_piso;
    import uart_pkg::*;

    typedef struct packed {
        logic tx;
        logic done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_en = 1'b0;
    logic [31:0] cyc = '0;
    logic [1:0]  tb_ptype = PAR_NONE;
    logic [7:0]  last_data = '0;

    logic armed   = 1'b0;
    logic pending = 1'b0;
    logic tx_last = 1'b1;
    int   frame_ticks = 0;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    uart_tx_frame_piso_if bus ();

    uart_tx_frame_piso dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.i_baud_tick = tick_en && (cyc[3:0] == 4'hF);
    // Stand-in for the parity unit wired to DataReg.
    assign bus.i_parity_in = (tb_ptype == PAR_EVEN) ? ^bus.o_data_reg : ~^bus.o_data_reg;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : mon
        logic tick_s;
        logic armed_s;
        logic pend_s;
        exp_t e;
        tick_s  = bus.i_baud_tick;
        armed_s = armed;
        pend_s  = pending;
        #1;
        if (rst) begin
            tx_last = 1'b1;
        end else begin
            chk("busy", 32'(bus.o_busy), 32'(armed_s | pend_s));
            if (armed_s && tick_s) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                    armed = 1'b0;
                end else begin
                    e = sb_q.pop_front();
                    chk("tx_bit", 32'(bus.o_tx_out), 32'(e.tx));
                    chk("done_bit", 32'(bus.o_done), 32'(e.done));
                    frame_ticks++;
                    if (e.done) armed = 1'b0;
                end
            end else begin
                chk("tx_hold", 32'(bus.o_tx_out), 32'(tx_last));
                chk("done_idle", 32'(bus.o_done), 32'd0);
            end
            tx_last = bus.o_tx_out;
        end
    end

    task automatic push_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb);
        exp_t e;
        e = '{tx: 1'b0, done: 1'b0};
        sb_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e.tx = d[i];
            sb_q.push_back(e);
        end
        if (pt == PAR_ODD) begin
            e.tx = ~^d;
            sb_q.push_back(e);
        end else if (pt == PAR_EVEN) begin
            e.tx = ^d;
            sb_q.push_back(e);
        end
        e.tx = 1'b1;
        sb_q.push_back(e);
        if (sb) sb_q.push_back(e);
        e.done = 1'b1;
        sb_q.push_back(e);
    endtask

    // Called at a negedge with the framer idle.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                              input bit coincide);
        if (coincide) begin
            for (int i = 0; i < 40 && !bus.i_baud_tick; i++) @(negedge clk);
        end
        bus.i_data_in     = d;
        bus.i_parity_type = pt;
        bus.i_stop_bits   = sb;
        bus.i_send        = 1'b1;
        tb_ptype          = pt;
        last_data         = d;
        pending           = 1'b1;
        push_frame(d, pt, sb);
        @(negedge clk);
        bus.i_send        = 1'b0;
        pending           = 1'b0;
        frame_ticks       = 0;
        armed             = 1'b1;
        bus.i_data_in     = 8'($urandom);
        bus.i_parity_type = 2'($urandom);
        bus.i_stop_bits   = 1'($urandom);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 600 && armed; i++) @(negedge clk);
        if (armed) begin
            chk("frame_timeout", 32'(armed), 32'd0);
            armed = 1'b0;
            sb_q.delete();
        end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("data_reg_hold", 32'(bus.o_data_reg), 32'(last_data));
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < 600 && frame_ticks < n; i++) @(negedge clk);
        chk("tick_wait", 32'(frame_ticks), 32'(n));
    endtask

    initial begin
        bus.i_send        = 1'b0;
        bus.i_data_in     = '0;
        bus.i_parity_type = PAR_NONE;
        bus.i_stop_bits   = STOP_ONE;
        tick_en           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(bus.o_tx_out), 32'd1);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_data_reg", 32'(bus.o_data_reg), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(8'h55, PAR_NONE, STOP_ONE, 0); wait_frame(); @(negedge clk);
        send_frame(8'h07, PAR_ODD,  STOP_ONE, 0); wait_frame(); @(negedge clk);
        send_frame(8'h07, PAR_EVEN, STOP_ONE, 0); wait_frame(); @(negedge clk);
        send_frame(8'h55, PAR_EVEN, STOP_TWO, 0); wait_frame(); @(negedge clk);

        // Send while busy is dropped; next frame goes in the cycle after Done.
        send_frame(8'h81, PAR_ODD, STOP_ONE, 0);
        wait_ticks(3);
        bus.i_data_in = 8'hFF;
        bus.i_send    = 1'b1;
        @(negedge clk);
        bus.i_send    = 1'b0;
        wait_frame();
        @(negedge clk);
        chk("busy_after_done", 32'(bus.o_busy), 32'd0);
        send_frame(8'hA3, PAR_EVEN, STOP_TWO, 0);
        wait_ticks(4);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        tick_en = 1'b1;
        wait_frame();
        @(negedge clk);

        // Asynchronous reset while the line is low in the middle of the data bits.
        send_frame(8'hC5, PAR_NONE, STOP_ONE, 0);
        wait_ticks(5);
        chk("pre_rst_tx", 32'(bus.o_tx_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(bus.o_tx_out), 32'd1);
        chk("async_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("async_rst_done", 32'(bus.o_done), 32'd0);
        chk("async_rst_data", 32'(bus.o_data_reg), 32'd0);
        armed = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h3C, PAR_NONE, STOP_ONE, 0); wait_frame(); @(negedge clk);

        // Send lands on a baud tick: the start bit waits for the following tick.
        send_frame(8'h5A, PAR_ODD, STOP_TWO, 1); wait_frame(); @(negedge clk);

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
